// File: rtl/imem_boot_ctrl_if.sv
// imem_boot_ctrl_if
//   Groups the loader byte stream and the instruction-memory bus of the
//   boot controller.
//   Ports (signals):
//     byte_valid_in / byte_data_in / byte_ready_out : loader byte handshake
//     cpu_imem_addr_in                              : CPU fetch address
//     imem_addr_out / imem_wr_en_out / imem_wr_data_out : imem port
//   Modports: slave = boot controller side, master = loader/CPU/imem side.
interface imem_boot_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              byte_valid_in;
  logic [7:0]        byte_data_in;
  logic              byte_ready_out;
  logic [ADDR_W-1:0] cpu_imem_addr_in;
  logic [ADDR_W-1:0] imem_addr_out;
  logic              imem_wr_en_out;
  logic [31:0]       imem_wr_data_out;

  modport slave (
    input  byte_valid_in,
    input  byte_data_in,
    input  cpu_imem_addr_in,
    output byte_ready_out,
    output imem_addr_out,
    output imem_wr_en_out,
    output imem_wr_data_out
  );

  modport master (
    output byte_valid_in,
    output byte_data_in,
    output cpu_imem_addr_in,
    input  byte_ready_out,
    input  imem_addr_out,
    input  imem_wr_en_out,
    input  imem_wr_data_out
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
//   Receives a program over a byte stream (16-bit word count, then
//   little-endian 32-bit words), writes it into the instruction memory
//   from address 0, then releases the CPU and hands the imem address
//   port over to the CPU fetch address. An oversized length is a
//   sticky error that keeps the CPU in reset.
//   Ports:
//     clk            : clock, all state changes on the rising edge
//     rst            : synchronous active-high reset
//     bus            : byte stream + imem bus (imem_boot_ctrl_if.slave)
//     cpu_rst_out    : active-high reset to the CPU
//     load_done_out  : program loaded, CPU running
//     err_out        : length error, sticky until rst
//
//   state | meaning
//   ------+---------------------------------------------------------
//   LEN0  | waiting for word count low byte
//   LEN1  | waiting for word count high byte
//   DATA  | collecting the 4 bytes of the current word
//   WRITE | one-cycle imem write of the assembled word
//   RUN   | load complete, CPU released, imem address from CPU
//   ERR   | word count above MAX_WORDS, terminal until rst
module imem_boot_ctrl #(
  parameter int          ADDR_W    = 16,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic                    clk,
  input  logic                    rst,
  imem_boot_ctrl_if.slave         bus,
  output logic                    cpu_rst_out,
  output logic                    load_done_out,
  output logic                    err_out
);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_len;
  logic [15:0] r_idx;
  logic [1:0]  r_bcnt;
  logic [31:0] r_word;

  logic        w_rx_state;
  logic        w_xfer;
  logic [15:0] w_len_full;
  logic [15:0] w_idx_inc;
  logic [17:0] w_idx_x4;
  logic        w_in_write;

  assign w_rx_state = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                      (r_state == S_DATA);

  // Ready is forced low during reset so no byte is taken on a reset edge.
  assign bus.byte_ready_out = w_rx_state && !rst;
  assign w_xfer             = bus.byte_valid_in && bus.byte_ready_out;

  // Full count as it will be once the high byte in LEN1 is stored.
  assign w_len_full = {bus.byte_data_in, r_len[7:0]};
  assign w_idx_inc  = r_idx + 16'd1;
  assign w_idx_x4   = {r_idx, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LEN0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LEN0: begin
        if (w_xfer) begin
          w_state_nxt = S_LEN1;
        end
      end
      S_LEN1: begin
        if (w_xfer) begin
          if (w_len_full == 16'd0) begin
            w_state_nxt = S_RUN;
          end else if (32'(w_len_full) > MAX_WORDS) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_xfer && (r_bcnt == 2'd3)) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_state_nxt = (w_idx_inc == r_len) ? S_RUN : S_DATA;
      end
      S_RUN:   w_state_nxt = S_RUN;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_LEN0;
    endcase
  end

  // Datapath: length, byte count, word assembly and write index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_bcnt <= '0;
      r_word <= '0;
    end else begin
      case (r_state)
        S_LEN0: begin
          if (w_xfer) begin
            r_len[7:0] <= bus.byte_data_in;
          end
        end
        S_LEN1: begin
          if (w_xfer) begin
            r_len[15:8] <= bus.byte_data_in;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            // Shift right so the first byte of a word ends up in [7:0];
            // the count wraps to 0 after the 4th byte.
            r_word <= {bus.byte_data_in, r_word[31:8]};
            r_bcnt <= r_bcnt + 2'd1;
          end
        end
        S_WRITE: begin
          r_idx <= w_idx_inc;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs are masked by rst so a reset asserted during WRITE never
  // lets the partial load reach the imem.
  assign w_in_write = (r_state == S_WRITE) && !rst;

  assign bus.imem_wr_en_out   = w_in_write;
  assign bus.imem_wr_data_out = w_in_write ? r_word : 32'd0;
  assign bus.imem_addr_out    = (r_state == S_RUN) ? bus.cpu_imem_addr_in
                                                   : ADDR_W'(w_idx_x4);

  assign cpu_rst_out   = (r_state != S_RUN) || rst;
  assign load_done_out = (r_state == S_RUN) && !rst;
  assign err_out       = (r_state == S_ERR) && !rst;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl
//   Randomized bench for imem_boot_ctrl. Programs are generated as word
//   lists; the expected imem writes are simply (i*4, word[i]) for each
//   word, and the byte stream is derived from the same word list.
module tb_imem_boot_ctrl;
  localparam int ADDR_W    = 16;
  localparam int MAX_WORDS = 16384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_rst_out, load_done_out, err_out;

  always #5 clk = ~clk;

  imem_boot_ctrl_if #(.ADDR_W(ADDR_W)) u_if ();

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (u_if.slave),
    .cpu_rst_out   (cpu_rst_out),
    .load_done_out (load_done_out),
    .err_out       (err_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor state
  int          cyc = 0;
  logic [47:0] obs_q[$];   // {addr[15:0], data[31:0]}
  int          acc_cnt   = 0;
  int          wr_cyc    = -1;
  int          done_cyc  = -1;
  logic        done_prev = 1'b0;

  logic [31:0] g_words[$];
  logic [7:0]  g_bytes[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && u_if.byte_valid_in && u_if.byte_ready_out) acc_cnt++;
    if (u_if.imem_wr_en_out) begin
      obs_q.push_back({u_if.imem_addr_out, u_if.imem_wr_data_out});
      wr_cyc = cyc;
      chk("ready_in_write", 64'(u_if.byte_ready_out), 64'd0);
      chk("write_cpu_in_rst", 64'(cpu_rst_out), 64'd1);
    end
    if (!rst) chk("cpu_rst_vs_done", 64'(cpu_rst_out), 64'(!load_done_out));
    if (load_done_out && !done_prev) done_cyc = cyc;
    done_prev = load_done_out;
  end

  task automatic do_reset();
    rst = 1'b1;
    u_if.byte_valid_in = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready",   64'(u_if.byte_ready_out),   64'd0);
    chk("rst_cpu_rst", 64'(cpu_rst_out),           64'd1);
    chk("rst_wr_en",   64'(u_if.imem_wr_en_out),   64'd0);
    chk("rst_wr_data", 64'(u_if.imem_wr_data_out), 64'd0);
    chk("rst_done",    64'(load_done_out),         64'd0);
    chk("rst_err",     64'(err_out),               64'd0);
    rst = 1'b0;
    obs_q.delete();
    acc_cnt  = 0;
    wr_cyc   = -1;
    done_cyc = -1;
    #1;
    chk("post_rst_ready", 64'(u_if.byte_ready_out), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    u_if.byte_valid_in = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    u_if.byte_valid_in = 1'b1;
    u_if.byte_data_in  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (u_if.byte_ready_out) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    u_if.byte_valid_in = 1'b0;
    if (!ok) chk("byte_timeout", 64'd0, 64'd1);
  endtask

  function automatic void build_stream(input int n);
    g_bytes.delete();
    g_bytes.push_back(8'(n));
    g_bytes.push_back(8'(n >> 8));
    for (int i = 0; i < g_words.size(); i++)
      for (int k = 0; k < 4; k++) g_bytes.push_back(8'(g_words[i] >> (8 * k)));
  endfunction

  task automatic feed(input int maxgap);
    for (int i = 0; i < g_bytes.size(); i++) begin
      int gap = 0;
      if (maxgap > 0 && $urandom_range(0, 1) == 1) gap = $urandom_range(1, maxgap);
      send_byte(g_bytes[i], gap);
    end
  endtask

  task automatic check_writes(input string tag);
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_wr_count"}, 64'(obs_q.size()), 64'(g_words.size()));
    for (int i = 0; i < g_words.size() && i < obs_q.size(); i++) begin
      chk({tag, "_addr"}, 64'(obs_q[i][47:32]), 64'(16'(i * 4)));
      chk({tag, "_data"}, 64'(obs_q[i][31:0]),  64'(g_words[i]));
    end
    chk({tag, "_done"}, 64'(load_done_out), 64'd1);
  endtask

  task automatic present_idle_bytes(input string tag);
    int acc0 = acc_cnt;
    int wr0  = obs_q.size();
    u_if.byte_valid_in = 1'b1;
    repeat (8) begin
      u_if.byte_data_in = 8'($urandom);
      @(posedge clk); #1;
    end
    u_if.byte_valid_in = 1'b0;
    chk({tag, "_accepted"}, 64'(acc_cnt - acc0), 64'd0);
    chk({tag, "_writes"},   64'(obs_q.size() - wr0), 64'd0);
  endtask

  initial begin
    u_if.byte_valid_in    = 1'b0;
    u_if.byte_data_in     = 8'h00;
    u_if.cpu_imem_addr_in = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed two-word load, valid held high.
    g_words = '{32'h0010_0513, 32'h0020_0593};
    build_stream(2);
    feed(0);
    check_writes("n2");
    chk("n2_done_after_last_write", 64'(done_cyc - wr_cyc), 64'd1);
    chk("n2_cpu_rst", 64'(cpu_rst_out), 64'd0);
    present_idle_bytes("run_ignore");
    chk("run_done_held", 64'(load_done_out), 64'd1);

    // Empty program.
    do_reset();
    g_words.delete();
    send_byte(8'h00, 0);
    chk("n0_not_run_yet", 64'(load_done_out), 64'd0);
    send_byte(8'h00, 0);
    chk("n0_run_next_cycle", 64'(load_done_out), 64'd1);
    u_if.cpu_imem_addr_in = 16'h0040; #1;
    chk("n0_passthru_40", 64'(u_if.imem_addr_out), 64'h40);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] a = 16'($urandom);
      u_if.cpu_imem_addr_in = a; #1;
      chk("n0_passthru_rand", 64'(u_if.imem_addr_out), 64'(a));
    end
    check_writes("n0");

    // Oversized length.
    do_reset();
    u_if.cpu_imem_addr_in = 16'h1234;
    send_byte(8'(MAX_WORDS + 1), 0);
    send_byte(8'((MAX_WORDS + 1) >> 8), 0);
    #1;
    chk("err_flag",    64'(err_out),              64'd1);
    chk("err_cpu_rst", 64'(cpu_rst_out),          64'd1);
    chk("err_ready",   64'(u_if.byte_ready_out),  64'd0);
    chk("err_addr",    64'(u_if.imem_addr_out),   64'd0);
    present_idle_bytes("err_ignore");
    chk("err_sticky",  64'(err_out),              64'd1);
    chk("err_no_writes", 64'(obs_q.size()),       64'd0);

    // Largest legal length is accepted.
    do_reset();
    send_byte(8'(MAX_WORDS), 0);
    send_byte(8'(MAX_WORDS >> 8), 0);
    #1;
    chk("max_len_no_err", 64'(err_out),             64'd0);
    chk("max_len_ready",  64'(u_if.byte_ready_out), 64'd1);

    // Random programs with random idle gaps.
    for (int t = 0; t < 4; t++) begin
      int n = $urandom_range(1, 6);
      do_reset();
      g_words.delete();
      for (int i = 0; i < n; i++) g_words.push_back($urandom);
      build_stream(n);
      feed((t == 0) ? 0 : 5);
      check_writes("rand");
    end

    // Reset in the middle of the second word, then reload one word.
    do_reset();
    g_words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    build_stream(3);
    for (int i = 0; i < 8; i++) send_byte(g_bytes[i], 0);
    chk("abort_cpu_rst", 64'(cpu_rst_out), 64'd1);
    do_reset();
    g_words = '{32'hDEAD_BEEF};
    build_stream(1);
    feed(2);
    check_writes("reload");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, is the imem byte-address width.
REQ-002 Parameter MAX_WORDS, default 16384, is the largest accepted program length in 32-bit words.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 byte_valid_in  input  1  loader byte stream valid.
REQ-006 byte_data_in  input  8  loader byte.
REQ-007 byte_ready_out  output  1  the block can accept a byte this cycle; a transfer occurs when valid and ready are both 1.
REQ-008 cpu_imem_addr_in  input  ADDR_W  CPU fetch address.
REQ-009 imem_addr_out  output  ADDR_W  address to the imem.
REQ-010 imem_wr_en_out  output  1  imem write strobe.
REQ-011 imem_wr_data_out  output  32  imem write word.
REQ-012 cpu_rst_out  output  1  active-high reset to cpu_top.
REQ-013 load_done_out  output  1  program loaded and the CPU released.
REQ-014 err_out  output  1  length error, sticky until rst.

Function
REQ-015 FSM states are LEN0, LEN1, DATA, WRITE, RUN and ERR; all outputs except imem_addr_out are decoded from registered state and registers.
REQ-016 Stream format: 16-bit word count N, low byte first, then N words of 4 bytes each, little-endian (first byte goes to bits [7:0]).
REQ-017 byte_ready_out is 1 in LEN0, LEN1 and DATA, 0 in WRITE, RUN and ERR, and 0 whenever rst is 1.
REQ-018 LEN0 -> LEN1 on a transfer; the byte is stored as N[7:0].
REQ-019 LEN1 on a transfer stores N[15:8] and goes to:
- RUN if N = 0;
- ERR if N > MAX_WORDS;
- DATA otherwise.
REQ-020 DATA counts bytes 0..3 and shifts each byte into the assembly register; on the 4th transfer it goes to WRITE.
REQ-021 WRITE lasts exactly one cycle, with:
- imem_wr_en_out = 1;
- imem_wr_data_out = the assembled word;
- imem_addr_out = idx*4, truncated to ADDR_W.
REQ-022 On leaving WRITE, idx increments; the next state is RUN if the new idx equals N, else DATA.
REQ-023 idx is 16 bits and never wraps, because N <= MAX_WORDS.
REQ-024 imem_addr_out = cpu_imem_addr_in (combinational pass-through) in RUN; in every other state it is idx*4.
REQ-025 cpu_rst_out is 1 in every state except RUN; it deasserts in the first cycle the state register holds RUN.
REQ-026 load_done_out = 1 exactly when the state is RUN.
REQ-027 err_out = 1 exactly when the state is ERR.
REQ-028 RUN and ERR are terminal; only rst leaves them, and all bytes presented there are ignored (ready stays 0).
REQ-029 imem_wr_en_out is 0 in all states except WRITE; a write is never issued while cpu_rst_out is 0.
REQ-030 An idle gap (valid = 0) in any receive state holds the state, byte count and partial word unchanged.

Reset
REQ-031 When rst is 1 at a clock edge, the next state is LEN0 and idx, N, the byte count and the assembly register are cleared.
REQ-032 Reset output values: cpu_rst_out = 1, imem_wr_en_out = 0, imem_wr_data_out = 0, load_done_out = 0, err_out = 0, byte_ready_out = 0 while rst is high.
REQ-033 Asserting rst mid-load (any state, including WRITE) aborts the load without completing a partial write; the CPU is held in reset until a new complete load finishes.
REQ-034 A load after reset overwrites imem from address 0.

Verification
REQ-035 Load N=2 (bytes 02 00 13 05 10 00 93 05 20 00) with valid held high -> exactly two write pulses: addr 0 data 0x00100513, then addr 4 data 0x00200593. cpu_rst_out falls one cycle after the second write and load_done_out rises in that same cycle.
REQ-036 Load N=0 (bytes 00 00) -> no write pulse; RUN reached the cycle after the 2nd byte; imem_addr_out then tracks cpu_imem_addr_in (drive 0x0040 -> observe 0x0040).
REQ-037 Load N = MAX_WORDS+1 -> err_out = 1, no write pulse, cpu_rst_out stays 1, byte_ready_out = 0 for all subsequent bytes.
REQ-038 Random valid gaps (1-5 idle cycles) within a word, and random gaps between words -> written words and addresses are identical to the gap-free run; byte_ready_out = 0 in every WRITE cycle.
REQ-039 Assert rst for one cycle after the 2nd byte of the 2nd word, then reload N=1 with word 0xDEADBEEF -> a single write of addr 0 data 0xDEADBEEF; no write from the aborted load appears.
REQ-040 After reaching RUN, present 8 more valid bytes -> none accepted, no writes, load_done_out stays 1.
